segway_seq: RTL and testbench

SEGWAY_SEQ -- requirements
Module: segway_seq

---
 rtl/segway_seq.sv | 144 ++++++++++++++
 tb/tb_segway_seq.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/segway_seq.sv
// Segway soft-start/soft-stop sequencer: ramps the torque scale up and down on a prescaled tick.
// Define SEQ_OVERSPD_LIMIT_EN to compile in the LIMIT (overspeed back-off) state.
module segway_seq #(
    parameter int unsigned SS_PRESC  = 10,
    parameter logic [7:0]  LIM_FLOOR = 8'hC0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run_req,
    input  logic       too_fast,
    output logic       pwr_up,
    output logic [7:0] ss_tmr,
    output logic       en_steer,
    output logic       overspd,
    output logic [2:0] seq_st
);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StRamp  = 3'd1,
        StRun   = 3'd2,
        StDown  = 3'd3,
        StLimit = 3'd4
    } seq_st_e;

    seq_st_e             state_q, state_d;
    logic [SS_PRESC-1:0] presc_q, presc_d;
    logic [7:0]          ss_tmr_q, ss_tmr_d;
    logic                pwr_up_q, pwr_up_d;
    logic                en_steer_q, en_steer_d;
    logic                tick;
    logic                limit_req;

    assign tick = &presc_q;

`ifdef SEQ_OVERSPD_LIMIT_EN
    logic overspd_q, overspd_d;

    assign limit_req = too_fast;
    assign overspd   = overspd_q;
`else
    logic       unused_too_fast;
    logic [7:0] unused_lim_floor;

    assign unused_too_fast  = too_fast;
    assign unused_lim_floor = LIM_FLOOR;
    assign limit_req        = 1'b0;
    assign overspd          = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        ss_tmr_d = ss_tmr_q;
        presc_d  = (state_q == StIdle) ? '0 : presc_q + SS_PRESC'(1);
        // Leaving on run_req takes precedence over any tick action on the same edge.
        unique case (state_q)
            StIdle: begin
                if (run_req) state_d = StRamp;
            end
            StRamp: begin
                if (!run_req) begin
                    state_d = StDown;
                end else if (limit_req) begin
                    state_d = StLimit;
                end else if (tick) begin
                    if (ss_tmr_q >= 8'hFE) begin
                        ss_tmr_d = 8'hFF;
                        state_d  = StRun;
                    end else begin
                        ss_tmr_d = ss_tmr_q + 8'd1;
                    end
                end
            end
            StRun: begin
                if (!run_req) begin
                    state_d = StDown;
                end else if (limit_req) begin
                    state_d = StLimit;
                end
            end
            StDown: begin
                if (run_req) begin
                    state_d = StRamp;
                end else if (tick) begin
                    if (ss_tmr_q <= 8'h01) begin
                        ss_tmr_d = 8'h00;
                        state_d  = StIdle;
                    end else begin
                        ss_tmr_d = ss_tmr_q - 8'd1;
                    end
                end
            end
`ifdef SEQ_OVERSPD_LIMIT_EN
            StLimit: begin
                if (!run_req) begin
                    state_d = StDown;
                end else if (tick) begin
                    if (!too_fast) begin
                        state_d = StRamp;
                    end else if (ss_tmr_q > LIM_FLOOR) begin
                        ss_tmr_d = ss_tmr_q - 8'd1;
                    end
                end
            end
`endif
            default: state_d = StIdle;
        endcase

        pwr_up_d   = (state_d != StIdle);
        // Steering comes on one clock after RUN is entered, and drops on any exit edge.
        en_steer_d = (state_q == StRun) && (state_d == StRun);
`ifdef SEQ_OVERSPD_LIMIT_EN
        overspd_d  = (state_d == StLimit);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            presc_q    <= '0;
            ss_tmr_q   <= 8'h00;
            pwr_up_q   <= 1'b0;
            en_steer_q <= 1'b0;
`ifdef SEQ_OVERSPD_LIMIT_EN
            overspd_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            ss_tmr_q   <= ss_tmr_d;
            pwr_up_q   <= pwr_up_d;
            en_steer_q <= en_steer_d;
`ifdef SEQ_OVERSPD_LIMIT_EN
            overspd_q  <= overspd_d;
`endif
        end
    end

    assign pwr_up   = pwr_up_q;
    assign ss_tmr   = ss_tmr_q;
    assign en_steer = en_steer_q;
    assign seq_st   = state_q;

endmodule

// File: tb/tb_segway_seq.sv
// Bench for segway_seq (SS_PRESC=2): directed sequence plus randomized run_req/too_fast
// traffic, every clock compared against a behavioural model of the sequencer rules.
module tb_segway_seq;

    localparam int unsigned PRESC  = 2;
    localparam int          PERIOD = 1 << PRESC;
    localparam int          FLOOR  = 'hC0;
`ifdef SEQ_OVERSPD_LIMIT_EN
    localparam bit LIM_EN = 1'b1;
`else
    localparam bit LIM_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run_req;
    logic       too_fast;
    logic       pwr_up;
    logic [7:0] ss_tmr;
    logic       en_steer;
    logic       overspd;
    logic [2:0] seq_st;

    int checks = 0;
    int errors = 0;

    int m_st;
    int m_tmr;
    int m_phase;
    bit m_pwr;
    bit m_steer;
    bit m_ovr;

    segway_seq #(
        .SS_PRESC (PRESC),
        .LIM_FLOOR(8'hC0)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .run_req (run_req),
        .too_fast(too_fast),
        .pwr_up  (pwr_up),
        .ss_tmr  (ss_tmr),
        .en_steer(en_steer),
        .overspd (overspd),
        .seq_st  (seq_st)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_tmr = 0; m_phase = 0;
        m_pwr = 1'b0; m_steer = 1'b0; m_ovr = 1'b0;
    endtask

    // States: 0 idle, 1 ramp, 2 run, 3 down, 4 limit; tick every PERIOD clocks once active.
    task automatic model_clock(input bit rr, input bit tf);
        bit tk;
        int nst;
        int ntmr;
        tk   = (m_st != 0) && (m_phase == PERIOD - 1);
        nst  = m_st;
        ntmr = m_tmr;
        case (m_st)
            0: if (rr) nst = 1;
            1: begin
                if (!rr) nst = 3;
                else if (LIM_EN && tf) nst = 4;
                else if (tk) begin
                    ntmr = (m_tmr < 255) ? m_tmr + 1 : 255;
                    if (ntmr == 255) nst = 2;
                end
            end
            2: begin
                if (!rr) nst = 3;
                else if (LIM_EN && tf) nst = 4;
            end
            3: begin
                if (rr) nst = 1;
                else if (tk) begin
                    ntmr = (m_tmr > 0) ? m_tmr - 1 : 0;
                    if (ntmr == 0) nst = 0;
                end
            end
            4: begin
                if (!rr) nst = 3;
                else if (tk) begin
                    if (!tf) nst = 1;
                    else if (m_tmr > FLOOR) ntmr = m_tmr - 1;
                end
            end
            default: nst = 0;
        endcase
        m_phase = (m_st == 0) ? 0 : (m_phase + 1) % PERIOD;
        m_steer = (m_st == 2) && (nst == 2);
        m_st    = nst;
        m_tmr   = ntmr;
        m_pwr   = (nst != 0);
        m_ovr   = (nst == 4);
    endtask

    task automatic step(input string tag);
        bit rr;
        bit tf;
        rr = run_req;
        tf = too_fast;
        @(posedge clk);
        model_clock(rr, tf);
        #1;
        chk(tag, {seq_st, ss_tmr, pwr_up, en_steer, overspd},
            {m_st[2:0], m_tmr[7:0], m_pwr, m_steer, m_ovr});
    endtask

    task automatic run_until(input string tag, input bit on_tmr, input int val,
                             input int budget, output int n);
        n = 0;
        while (((on_tmr ? int'(ss_tmr) : int'(seq_st)) != val) && (n < budget)) begin
            step(tag);
            n++;
        end
        chk({tag, "_reached"}, on_tmr ? 32'(ss_tmr) : 32'(seq_st), val);
    endtask

    // Asynchronous reset pulse placed between clock edges; outputs must clear before the next edge.
    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        chk(tag, {seq_st, ss_tmr, pwr_up, en_steer, overspd}, 0);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int n;
        rst_n    = 1'b0;
        run_req  = 1'b0;
        too_fast = 1'b0;
        model_reset();
        #1;
        chk("rst_outputs", {seq_st, ss_tmr, pwr_up, en_steer, overspd}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        repeat (3) step("idle_hold");
        chk("idle_st", seq_st, 0);

        // Full ramp up from IDLE.
        run_req = 1'b1;
        step("ramp_entry");
        chk("ramp_st", seq_st, 1);
        chk("ramp_pwr", pwr_up, 1);
        chk("ramp_tmr0", ss_tmr, 8'h00);
        repeat (3) step("ramp_first");
        chk("ramp_pretick", ss_tmr, 8'h00);
        step("ramp_first");
        chk("ramp_tmr1", ss_tmr, 8'h01);
        repeat (1015) step("ramp_run");
        chk("ramp_fe_st", seq_st, 1);
        chk("ramp_fe_tmr", ss_tmr, 8'hFE);
        step("ramp_last");
        chk("run_st", seq_st, 2);
        chk("run_tmr", ss_tmr, 8'hFF);
        chk("run_steer_late", en_steer, 0);
        step("run_hold");
        chk("run_steer", en_steer, 1);

`ifdef SEQ_OVERSPD_LIMIT_EN
        too_fast = 1'b1;
        step("lim_entry");
        chk("lim_st", seq_st, 4);
        chk("lim_ovr", overspd, 1);
        chk("lim_steer", en_steer, 0);
        repeat (399) step("lim_hold");
        chk("lim_floor", ss_tmr, 8'hC0);
        chk("lim_st_hold", seq_st, 4);
        too_fast = 1'b0;
        run_until("lim_exit", 1'b0, 1, 8, n);
        chk("lim_exit_ovr", overspd, 0);
        run_until("lim_reramp", 1'b0, 2, 300, n);
        chk("lim_reramp_ticks", n, 63 * PERIOD);
        chk("lim_reramp_tmr", ss_tmr, 8'hFF);
        step("lim_run");
        chk("lim_run_steer", en_steer, 1);
`else
        too_fast = 1'b1;
        repeat (20) step("nolim_hold");
        chk("nolim_st", seq_st, 2);
        chk("nolim_ovr", overspd, 0);
        chk("nolim_tmr", ss_tmr, 8'hFF);
        too_fast = 1'b0;
`endif

        // Full ramp down to IDLE.
        run_req = 1'b0;
        step("down_entry");
        chk("down_st", seq_st, 3);
        chk("down_steer", en_steer, 0);
        chk("down_pwr", pwr_up, 1);
        run_until("down_run", 1'b0, 0, 1100, n);
        chk("down_len", 32'(n >= 1017 && n <= 1020), 1);
        chk("down_pwr_off", pwr_up, 0);
        chk("down_tmr0", ss_tmr, 8'h00);

        // Reverse from DOWN back into RAMP without a jump.
        run_req = 1'b1;
        run_until("rev_up", 1'b1, 'h50, 400, n);
        run_req = 1'b0;
        step("rev_down");
        chk("rev_down_st", seq_st, 3);
        run_until("rev_fall", 1'b1, 'h40, 100, n);
        run_req = 1'b1;
        step("rev_resume");
        chk("rev_resume_st", seq_st, 1);
        chk("rev_resume_tmr", ss_tmr, 8'h40);
        run_until("rev_tick", 1'b1, 'h41, PERIOD, n);

        // Asynchronous reset mid-RAMP, then IDLE must wait for run_req.
        run_until("mid_ramp", 1'b1, 'h80, 400, n);
        chk("mid_ramp_st", seq_st, 1);
        run_req = 1'b0;
        async_reset("rst_async");
        repeat (3) step("rst_idle");
        chk("rst_idle_st", seq_st, 0);
        run_req = 1'b1;
        step("rst_restart");
        chk("rst_restart_st", seq_st, 1);

        // Randomized traffic with occasional asynchronous resets.
        for (int seg = 0; seg < 40; seg++) begin
            run_req  = ($urandom_range(0, 3) != 0);
            too_fast = ($urandom_range(0, 4) == 0);
            repeat ($urandom_range(1, 200)) step("rand");
            if ($urandom_range(0, 9) == 0) async_reset("rand_rst");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
